sram_rr_arbiter: RTL and testbench
==================================

SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter AddrWidth, default 32, SRAM word-address width.
REQ-003 SHALL have parameter DataWidth, default 64, data width; byte-enable width BeWidth = DataWidth/8.
REQ-004 SHALL have port clk_i  input  1  clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port halt_i  input  1  when high, no new grants are issued (preload/backdoor window).
REQ-007 SHALL have port req_i  input  NumReq  per-requester access request.
REQ-008 SHALL have port we_i  input  NumReq  per-requester write enable.
REQ-009 SHALL have port addr_i  input  NumReq*AddrWidth  per-requester address.
REQ-010 SHALL have port wdata_i  input  NumReq*DataWidth  per-requester write data.
REQ-011 SHALL have port be_i  input  NumReq*BeWidth  per-requester byte enables.
REQ-012 SHALL have port gnt_o  output  NumReq  one-hot grant, combinational.
REQ-013 SHALL have port rvalid_o  output  NumReq  response valid, one cycle after grant.
REQ-014 SHALL have port rdata_o  output  DataWidth  shared response data, qualified by rvalid_o.
REQ-015 SHALL have port sram_req_o, sram_we_o (1), sram_addr_o (AddrWidth), sram_wdata_o (DataWidth), sram_be_o (BeWidth)  outputs  SRAM command.
REQ-016 SHALL have port sram_rdata_i  input  DataWidth  SRAM read data, valid one cycle after sram_req_o.
REQ-017 SHALL have port busy_o  output  1  high while any req_i is high or a response is outstanding.

Function
REQ-018 SHALL grant at most one requester per cycle; gnt_o SHALL be zero-or-one-hot at all times.
REQ-019 SHALL grant only when halt_i is low and at least one req_i is high; grant is combinational in the same cycle.
REQ-020 SHALL select the winner round-robin: first requesting index at or above priority pointer ptr, wrapping from NumReq-1 to 0.
REQ-021 SHALL, on a grant to index k, update ptr to (k+1) mod NumReq at the next clock edge; ptr unchanged without a grant.
REQ-022 SHALL drive sram_req_o = |gnt_o and route we/addr/wdata/be of the winner to the sram_* outputs; sram_* data outputs SHALL be zero when no grant.
REQ-023 SHALL register the winner index and a valid bit; in the following cycle assert rvalid_o[k] only for that winner, for both reads and writes.
REQ-024 SHALL drive rdata_o = sram_rdata_i when a read response is valid, zero otherwise (including write responses).
REQ-025 SHALL allow back-to-back grants every cycle (grant in cycle n and n+1, responses in n+1 and n+2).
REQ-026 SHALL permit the same requester to be granted consecutively only when it is the sole requester.
REQ-027 SHALL guarantee any continuously asserted request is granted within NumReq cycles while halt_i is low.
REQ-028 SHALL, when halt_i rises, still deliver the response for a grant issued in the previous cycle.
REQ-029 SHALL ignore we_i/addr_i/wdata_i/be_i of non-granted requesters.
REQ-030 SHALL compute busy_o = |req_i OR response-valid register.

Reset
REQ-031 SHALL, while rst is low, force ptr = 0, response-valid = 0, winner index = 0, hence rvalid_o = 0, rdata_o = 0.
REQ-032 SHALL, on rst asserted mid-operation, drop any in-flight response (no rvalid_o after release).
REQ-033 SHALL issue no grant while rst is low regardless of req_i.

Verification
REQ-034 Single requester: NumReq=4, req_i=0001, read addr 0x10, SRAM returns 0xDEAD -> gnt_o=0001 same cycle, rvalid_o=0001 and rdata_o=0xDEAD next cycle.
REQ-035 All request: req_i=1111 held 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; one sram_req_o per cycle.
REQ-036 Wrap-around: ptr=3, req_i=0101 -> grant index 0, then ptr=1, next grant index 2.
REQ-037 Halt: req_i=0010, halt_i=1 for 5 cycles -> gnt_o=0, sram_req_o=0; halt_i low -> grant index 1 same cycle; halt rising the cycle after a grant still yields rvalid.
REQ-038 Write: req_i=1000, we=1, be=0x0F, wdata=0x1234 -> sram_we_o=1, sram_be_o=0x0F, rvalid_o=1000 next cycle with rdata_o=0.
REQ-039 Reset mid-op: grant index 2 then rst low for 1 cycle -> rvalid_o stays 0, ptr=0 after release, next all-request grant is index 0.

Source files
------------

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumReq requesters.
// Combinational grant, one-cycle registered response routing.
module sram_rr_arbiter #(
   parameter  int NumReq    = 4,
   parameter  int AddrWidth = 32,
   parameter  int DataWidth = 64,
   localparam int BeWidth   = DataWidth / 8,
   localparam int IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst,
   input  logic                        halt_i,
   input  logic [NumReq-1:0]           req_i,
   input  logic [NumReq-1:0]           we_i,
   input  logic [NumReq*AddrWidth-1:0] addr_i,
   input  logic [NumReq*DataWidth-1:0] wdata_i,
   input  logic [NumReq*BeWidth-1:0]   be_i,
   output logic [NumReq-1:0]           gnt_o,
   output logic [NumReq-1:0]           rvalid_o,
   output logic [DataWidth-1:0]        rdata_o,
   output logic                        sram_req_o,
   output logic                        sram_we_o,
   output logic [AddrWidth-1:0]        sram_addr_o,
   output logic [DataWidth-1:0]        sram_wdata_o,
   output logic [BeWidth-1:0]          sram_be_o,
   input  logic [DataWidth-1:0]        sram_rdata_i,
   output logic                        busy_o
);

   logic [IdxW-1:0]   r_ptr;
   logic [IdxW-1:0]   r_idx;
   logic              r_valid;
   logic              r_rd;

   logic [NumReq-1:0] w_gnt;
   logic [IdxW-1:0]   w_idx;
   logic              w_found;
   int                w_j;

   // Scan from the pointer upward, wrapping; first requester wins.
   always_comb begin
      w_gnt   = '0;
      w_idx   = '0;
      w_found = 1'b0;
      w_j     = 0;
      if (rst && !halt_i) begin
         for (int i = 0; i < NumReq; i++) begin
            w_j = int'(r_ptr) + i;
            if (w_j >= NumReq) w_j = w_j - NumReq;
            if (!w_found && req_i[w_j]) begin
               w_found = 1'b1;
               w_idx   = IdxW'(w_j);
            end
         end
         if (w_found) w_gnt[w_idx] = 1'b1;
      end
   end

   always_comb begin
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      for (int k = 0; k < NumReq; k++) begin
         if (w_gnt[k]) begin
            sram_we_o    = we_i[k];
            sram_addr_o  = addr_i[k*AddrWidth +: AddrWidth];
            sram_wdata_o = wdata_i[k*DataWidth +: DataWidth];
            sram_be_o    = be_i[k*BeWidth +: BeWidth];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         r_ptr   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_rd    <= 1'b0;
      end else begin
         r_valid <= w_found;
         if (w_found) begin
            r_idx <= w_idx;
            r_rd  <= !sram_we_o;
            r_ptr <= (w_idx == IdxW'(NumReq - 1)) ? '0 : w_idx + 1'b1;
         end
      end
   end

   always_comb begin
      rvalid_o = '0;
      if (r_valid) rvalid_o[r_idx] = 1'b1;
   end

   assign gnt_o      = w_gnt;
   assign sram_req_o = |w_gnt;
   assign rdata_o    = (r_valid && r_rd) ? sram_rdata_i : '0;
   assign busy_o     = |req_i | r_valid;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with default parameters.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_sram_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int BW = DW / 8;

   logic            clk_i = 1'b0;
   logic            rst;
   logic            halt_i;
   logic [N-1:0]    req_i;
   logic [N-1:0]    we_i;
   logic [N*AW-1:0] addr_i;
   logic [N*DW-1:0] wdata_i;
   logic [N*BW-1:0] be_i;
   logic [N-1:0]    gnt_o;
   logic [N-1:0]    rvalid_o;
   logic [DW-1:0]   rdata_o;
   logic            sram_req_o;
   logic            sram_we_o;
   logic [AW-1:0]   sram_addr_o;
   logic [DW-1:0]   sram_wdata_o;
   logic [BW-1:0]   sram_be_o;
   logic [DW-1:0]   sram_rdata_i;
   logic            busy_o;

   int n_tests = 0;
   int n_fail  = 0;

   sram_rr_arbiter #(
      .NumReq(N), .AddrWidth(AW), .DataWidth(DW)
   ) dut (
      .clk_i(clk_i), .rst(rst), .halt_i(halt_i),
      .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
      .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
      .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst          = 1'b0;
      halt_i       = 1'b0;
      req_i        = 4'b1111;
      we_i         = '0;
      addr_i       = '0;
      wdata_i      = '0;
      be_i         = '0;
      sram_rdata_i = 64'hDEAD;

      // Reset holds off grants and responses
      #2;
      chk("rst_gnt", 64'(gnt_o), 64'h0);
      chk("rst_sreq", 64'(sram_req_o), 64'h0);
      step();
      chk("rst_rvalid", 64'(rvalid_o), 64'h0);
      chk("rst_rdata", rdata_o, 64'h0);
      chk("rst_busy", 64'(busy_o), 64'h1);

      // Single requester read
      req_i = 4'b0000;
      rst   = 1'b1;
      #1;
      chk("idle_busy", 64'(busy_o), 64'h0);
      chk("idle_addr", 64'(sram_addr_o), 64'h0);
      req_i        = 4'b0001;
      addr_i[31:0] = 32'h10;
      addr_i[63:32] = 32'h99;
      #1;
      chk("rd_gnt", 64'(gnt_o), 64'h1);
      chk("rd_sreq", 64'(sram_req_o), 64'h1);
      chk("rd_addr", 64'(sram_addr_o), 64'h10);
      chk("rd_we", 64'(sram_we_o), 64'h0);
      step();
      req_i = 4'b0000;
      #1;
      chk("rd_rvalid", 64'(rvalid_o), 64'h1);
      chk("rd_rdata", rdata_o, 64'hDEAD);
      chk("rd_busy", 64'(busy_o), 64'h1);
      step();
      chk("rd_rvalid_off", 64'(rvalid_o), 64'h0);

      // All request from reset: 0,1,2,3,0,1,2,3
      rst = 1'b0;
      step();
      rst   = 1'b1;
      req_i = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("all_gnt%0d", i), 64'(gnt_o), 64'(1 << (i % 4)));
         chk($sformatf("all_sreq%0d", i), 64'(sram_req_o), 64'h1);
         step();
         chk($sformatf("all_rv%0d", i), 64'(rvalid_o), 64'(1 << (i % 4)));
      end

      // Wrap-around: grant 2 sets ptr=3, then 0101 -> 0 then 2
      req_i = 4'b0100;
      #1;
      chk("wr_pre_gnt", 64'(gnt_o), 64'h4);
      step();
      req_i = 4'b0101;
      #1;
      chk("wrap_gnt0", 64'(gnt_o), 64'h1);
      step();
      chk("wrap_gnt1", 64'(gnt_o), 64'h4);
      step();
      chk("wrap_gnt2", 64'(gnt_o), 64'h1);

      // Halt blocks grants; halt right after a grant keeps its response
      req_i  = 4'b0010;
      halt_i = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("halt_gnt%0d", i), 64'(gnt_o), 64'h0);
         chk($sformatf("halt_sreq%0d", i), 64'(sram_req_o), 64'h0);
         step();
      end
      halt_i = 1'b0;
      #1;
      chk("unhalt_gnt", 64'(gnt_o), 64'h2);
      step();
      halt_i = 1'b1;
      #1;
      chk("halt_rise_gnt", 64'(gnt_o), 64'h0);
      chk("halt_rise_rv", 64'(rvalid_o), 64'h2);
      chk("halt_rise_busy", 64'(busy_o), 64'h1);
      step();
      chk("halt_rv_off", 64'(rvalid_o), 64'h0);
      halt_i = 1'b0;

      // Write from requester 3; other lanes carry junk
      req_i   = 4'b1000;
      we_i    = 4'b1011;
      be_i    = 32'h0FAA_BBCC;
      wdata_i = {64'h1234, 64'h5555, 64'h6666, 64'h7777};
      addr_i  = {32'h40, 32'h1, 32'h2, 32'h3};
      #1;
      chk("wr_gnt", 64'(gnt_o), 64'h8);
      chk("wr_we", 64'(sram_we_o), 64'h1);
      chk("wr_be", 64'(sram_be_o), 64'h0F);
      chk("wr_wdata", sram_wdata_o, 64'h1234);
      chk("wr_addr", 64'(sram_addr_o), 64'h40);
      step();
      req_i = 4'b0000;
      we_i  = '0;
      #1;
      chk("wr_rvalid", 64'(rvalid_o), 64'h8);
      chk("wr_rdata", rdata_o, 64'h0);

      // Reset mid-op drops the in-flight response
      req_i = 4'b0100;
      #1;
      chk("mid_gnt", 64'(gnt_o), 64'h4);
      rst = 1'b0;
      #1;
      chk("mid_rst_gnt", 64'(gnt_o), 64'h0);
      step();
      chk("mid_rst_rv", 64'(rvalid_o), 64'h0);
      rst   = 1'b1;
      req_i = 4'b1111;
      #1;
      chk("post_rst_rv", 64'(rvalid_o), 64'h0);
      chk("post_rst_gnt", 64'(gnt_o), 64'h1);
      step();
      chk("post_rst_gnt2", 64'(gnt_o), 64'h2);
      chk("post_rst_rv2", 64'(rvalid_o), 64'h1);

      req_i = '0;
      step();
      step();
      chk("end_busy", 64'(busy_o), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
